// File: rtl/csr_file.sv
// Machine-mode CSR file: Zicsr accesses in WB, trap/mret stacking of mstatus,
// 64-bit cycle/instret counters and interrupt selection back to the controller.
module csr_file #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] MHARTID   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        mcause_update,
    input  logic [31:0] mcause,
    input  logic        mepc_updata,
    input  logic [31:0] pc_wb,
    input  logic        is_mret,
    input  logic        instr_retired,
    input  logic        irq_extern,
    input  logic        irq_soft,
    input  logic        irq_timer,
    output logic        extern_irq_taken,
    output logic        soft_irq_taken,
    output logic        timer_irq_taken,
    output logic [1:0]  privilege_mode,
    output logic [31:0] mepc,
    output logic [31:0] mtvec
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    logic        st_mie;
    logic        st_mpie;
    logic [1:0]  st_mpp;
    logic [31:0] mie_q;
    logic [31:0] mip_q;
    logic [31:0] mscratch_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        addr_ok;
    logic        ro_violation;
    logic        priv_violation;
    logic        csr_we;
    logic [31:0] irq_cand;
    logic        global_ie;

    // Read mux: old value of the addressed CSR, flags unimplemented addresses
    always_comb begin
        old_val = 32'h0;
        addr_ok = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:   old_val = {19'b0, st_mpp, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            ADDR_MISA:      old_val = MISA_VAL;
            ADDR_MIE:       old_val = mie_q;
            ADDR_MTVEC:     old_val = mtvec;
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = mepc;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MIP:       old_val = mip_q;
            ADDR_MCYCLE:    old_val = mcycle_q[31:0];
            ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
            ADDR_MINSTRET:  old_val = minstret_q[31:0];
            ADDR_MINSTRETH: old_val = minstret_q[63:32];
            ADDR_MHARTID:   old_val = MHARTID;
            default:        addr_ok = 1'b0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        case (csr_op)
            OP_RW:   new_val = csr_wdata;
            OP_RS:   new_val = old_val | csr_wdata;
            OP_RC:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // Read-only space only tolerates set/clear with a zero mask
    assign ro_violation   = (csr_addr[11:10] == 2'b11) &&
                            ((csr_op == OP_RW) || (csr_op[1] && (csr_wdata != 32'h0)));
    assign priv_violation = csr_addr[9:8] > privilege_mode;
    assign csr_illegal    = csr_en && (!addr_ok || ro_violation || priv_violation);
    assign csr_rdata      = old_val;
    assign csr_we         = csr_en && !csr_illegal && (csr_op != OP_READ) &&
                            !mcause_update && !is_mret;

    assign irq_cand         = mip_q & mie_q;
    assign global_ie        = st_mie || (privilege_mode == PRIV_U);
    assign extern_irq_taken = global_ie && irq_cand[11];
    assign soft_irq_taken   = global_ie && irq_cand[3] && !irq_cand[11];
    assign timer_irq_taken  = global_ie && irq_cand[7] && !irq_cand[11] && !irq_cand[3];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_mie         <= 1'b0;
            st_mpie        <= 1'b0;
            st_mpp         <= PRIV_U;
            privilege_mode <= PRIV_M;
            mie_q          <= 32'h0;
            mip_q          <= 32'h0;
            mtvec          <= MTVEC_RST & 32'hFFFF_FF00;
            mscratch_q     <= 32'h0;
            mepc           <= 32'h0;
            mcause_q       <= 32'h0;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mip_q <= {20'b0, irq_extern, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};

            // Trap beats mret, which beats any CSR write
            if (mcause_update) begin
                mcause_q       <= mcause;
                st_mpie        <= st_mie;
                st_mie         <= 1'b0;
                st_mpp         <= privilege_mode;
                privilege_mode <= PRIV_M;
                if (mepc_updata) begin
                    mepc <= pc_wb & ~32'h3;
                end
            end else if (is_mret) begin
                st_mie         <= st_mpie;
                st_mpie        <= 1'b1;
                privilege_mode <= st_mpp;
                st_mpp         <= PRIV_U;
            end else if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        st_mie  <= new_val[3];
                        st_mpie <= new_val[7];
                        st_mpp  <= new_val[12:11];
                    end
                    ADDR_MIE:      mie_q      <= new_val & MIE_MASK;
                    ADDR_MTVEC:    mtvec      <= {new_val[31:8], 8'h00};
                    ADDR_MSCRATCH: mscratch_q <= new_val;
                    ADDR_MEPC:     mepc       <= {new_val[31:2], 2'b00};
                    ADDR_MCAUSE:   mcause_q   <= new_val;
                    default:       ;
                endcase
            end

            // A write to either counter half freezes the whole counter for that cycle
            if (csr_we && (csr_addr == ADDR_MCYCLE)) begin
                mcycle_q[31:0] <= new_val;
            end else if (csr_we && (csr_addr == ADDR_MCYCLEH)) begin
                mcycle_q[63:32] <= new_val;
            end else begin
                mcycle_q <= mcycle_q + 64'd1;
            end

            if (csr_we && (csr_addr == ADDR_MINSTRET)) begin
                minstret_q[31:0] <= new_val;
            end else if (csr_we && (csr_addr == ADDR_MINSTRETH)) begin
                minstret_q[63:32] <= new_val;
            end else if (instr_retired) begin
                minstret_q <= minstret_q + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios then randomized traffic
// compared every cycle against a word-level reference model.
module tb_csr_file;

    logic        clk;
    logic        reset_n;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        mcause_update;
    logic [31:0] mcause;
    logic        mepc_updata;
    logic [31:0] pc_wb;
    logic        is_mret;
    logic        instr_retired;
    logic        irq_extern;
    logic        irq_soft;
    logic        irq_timer;
    logic        extern_irq_taken;
    logic        soft_irq_taken;
    logic        timer_irq_taken;
    logic [1:0]  privilege_mode;
    logic [31:0] mepc;
    logic [31:0] mtvec;

    csr_file dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .csr_en           (csr_en),
        .csr_op           (csr_op),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .csr_rdata        (csr_rdata),
        .csr_illegal      (csr_illegal),
        .mcause_update    (mcause_update),
        .mcause           (mcause),
        .mepc_updata      (mepc_updata),
        .pc_wb            (pc_wb),
        .is_mret          (is_mret),
        .instr_retired    (instr_retired),
        .irq_extern       (irq_extern),
        .irq_soft         (irq_soft),
        .irq_timer        (irq_timer),
        .extern_irq_taken (extern_irq_taken),
        .soft_irq_taken   (soft_irq_taken),
        .timer_irq_taken  (timer_irq_taken),
        .privilege_mode   (privilege_mode),
        .mepc             (mepc),
        .mtvec            (mtvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model state: whole CSR words, privilege and 64-bit counters
    logic [31:0]     m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [1:0]      m_priv;
    longint unsigned m_cycle, m_instret;

    logic [11:0] addr_tab [14] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hF14, 12'h7C0};

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mip = 0; m_mtvec = 0; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_priv = 2'b11; m_cycle = 0; m_instret = 0;
    endtask

    function automatic logic m_impl(input logic [11:0] a);
        foreach (addr_tab[i]) if (i < 13 && addr_tab[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00: return m_cycle[31:0];
            12'hB80: return m_cycle[63:32];
            12'hB02: return m_instret[31:0];
            12'hB82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_illegal();
        logic ro;
        ro = (csr_addr[11:10] == 2'b11) &&
             (csr_op == 2'b01 || (csr_op >= 2'b10 && csr_wdata != 0));
        return csr_en && (!m_impl(csr_addr) || ro || (csr_addr[9:8] > m_priv));
    endfunction

    function automatic logic [2:0] m_taken();
        logic [31:0] cand;
        cand = m_mip & m_mie;
        if (!(m_mstatus[3] || m_priv == 2'b00)) return 3'b000;
        if (cand[11]) return 3'b100;
        if (cand[3])  return 3'b010;
        if (cand[7])  return 3'b001;
        return 3'b000;
    endfunction

    // Model effect of one rising edge given the inputs currently applied
    task automatic model_edge();
        logic [31:0] old, nv;
        logic wr;
        longint unsigned cyc_n, ins_n;
        if (!reset_n) begin
            model_reset();
            return;
        end
        old = m_read(csr_addr);
        case (csr_op)
            2'b01:   nv = csr_wdata;
            2'b10:   nv = old | csr_wdata;
            2'b11:   nv = old & ~csr_wdata;
            default: nv = old;
        endcase
        wr    = csr_en && !m_illegal() && csr_op != 0 && !mcause_update && !is_mret;
        cyc_n = m_cycle + 1;
        ins_n = m_instret + (instr_retired ? 1 : 0);
        if (mcause_update) begin
            m_mcause  = mcause;
            m_mstatus = (32'(m_priv) << 11) | (32'(m_mstatus[3]) << 7);
            m_priv    = 2'b11;
            if (mepc_updata) m_mepc = pc_wb & ~32'h3;
        end else if (is_mret) begin
            m_priv    = m_mstatus[12:11];
            m_mstatus = (32'(m_mstatus[7]) << 3) | 32'h80;
        end else if (wr) begin
            case (csr_addr)
                12'h300: m_mstatus  = nv & 32'h1888;
                12'h304: m_mie      = nv & 32'h888;
                12'h305: m_mtvec    = nv & 32'hFFFF_FF00;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & ~32'h3;
                12'h342: m_mcause   = nv;
                12'hB00: cyc_n = {m_cycle[63:32], nv};
                12'hB80: cyc_n = {nv, m_cycle[31:0]};
                12'hB02: ins_n = {m_instret[63:32], nv};
                12'hB82: ins_n = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        m_cycle   = cyc_n;
        m_instret = ins_n;
        m_mip     = (32'(irq_extern) << 11) | (32'(irq_timer) << 7) | (32'(irq_soft) << 3);
    endtask

    logic [31:0] last_rdata;
    logic        last_ill;

    // Called at a negedge with inputs applied: check, clock once, advance model
    task automatic step();
        #1;
        last_rdata = csr_rdata;
        last_ill   = csr_illegal;
        chk("rdata", csr_rdata, m_read(csr_addr));
        chk("illegal", 32'(csr_illegal), 32'(m_illegal()));
        chk("priv", 32'(privilege_mode), 32'(m_priv));
        chk("mepc", mepc, m_mepc);
        chk("mtvec", mtvec, m_mtvec);
        chk("taken", 32'({extern_irq_taken, soft_irq_taken, timer_irq_taken}), 32'(m_taken()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        step();
        csr_en = 1'b0;
    endtask

    initial begin
        csr_en = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
        mcause_update = 0; mcause = 0; mepc_updata = 0; pc_wb = 0; is_mret = 0;
        instr_retired = 0; irq_extern = 0; irq_soft = 0; irq_timer = 0;
        reset_n = 0;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset_n = 1;

        csr(2'b00, 12'h305, 0); chk("rst_mtvec", last_rdata, 32'h0);
        csr(2'b00, 12'h300, 0); chk("rst_mstatus", last_rdata, 32'h0);
        csr(2'b00, 12'h301, 0); chk("rst_misa", last_rdata, 32'h4000_0100);
        chk("rst_priv", 32'(privilege_mode), 32'h3);

        csr(2'b01, 12'h340, 32'hA5A5_0000); chk("rw_old", last_rdata, 32'h0);
        csr(2'b10, 12'h340, 32'h0000_00FF); chk("rs_old", last_rdata, 32'hA5A5_0000);
        csr(2'b11, 12'h340, 32'hA500_0000); chk("rc_old", last_rdata, 32'hA5A5_00FF);
        csr(2'b00, 12'h340, 0);             chk("scratch_final", last_rdata, 32'h00A5_00FF);

        csr(2'b01, 12'h304, 32'h888);
        csr(2'b10, 12'h300, 32'h8);
        irq_timer = 1; irq_extern = 1; step();
        chk("irq_both", 32'({extern_irq_taken, soft_irq_taken, timer_irq_taken}), 32'b100);
        irq_extern = 0; step();
        chk("irq_timer", 32'({extern_irq_taken, soft_irq_taken, timer_irq_taken}), 32'b001);

        mcause_update = 1; mcause = 32'h8000_000B; mepc_updata = 1; pc_wb = 32'h0000_1236;
        step();
        mcause_update = 0; mepc_updata = 0;
        chk("trap_mepc", mepc, 32'h0000_1234);
        chk("trap_taken", 32'({extern_irq_taken, soft_irq_taken, timer_irq_taken}), 32'b000);
        csr(2'b00, 12'h300, 0); chk("trap_mstatus", last_rdata, 32'h0000_1880);
        csr(2'b00, 12'h342, 0); chk("trap_mcause", last_rdata, 32'h8000_000B);

        is_mret = 1; step(); is_mret = 0;
        csr(2'b00, 12'h300, 0); chk("mret_mstatus", last_rdata, 32'h0000_0088);
        is_mret = 1; step(); is_mret = 0;
        chk("mret_priv_u", 32'(privilege_mode), 32'h0);

        csr(2'b00, 12'h300, 0);           chk("u_mstatus_ill", 32'(last_ill), 32'h1);
        csr(2'b01, 12'h301, 32'h5);       chk("u_misa_ill", 32'(last_ill), 32'h1);
        mcause_update = 1; mcause = 32'h2; step(); mcause_update = 0;
        irq_timer = 0;
        csr(2'b10, 12'h301, 0);           chk("m_misa_rs0", 32'(last_ill), 32'h0);
        csr(2'b01, 12'hF14, 32'h1);       chk("hartid_rw_ill", 32'(last_ill), 32'h1);
        csr(2'b11, 12'hF14, 0);           chk("hartid_rc0", 32'(last_ill), 32'h0);

        csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        csr(2'b01, 12'hB80, 32'hFFFF_FFFF);
        csr(2'b00, 12'hB00, 0);           chk("cyc_max", last_rdata, 32'hFFFF_FFFF);
        csr(2'b00, 12'hB00, 0);           chk("cyc_wrap_lo", last_rdata, 32'h0);
        csr(2'b00, 12'hB80, 0);           chk("cyc_wrap_hi", last_rdata, 32'h0);
        csr(2'b01, 12'hB02, 32'h5);
        csr(2'b01, 12'hB82, 32'h0);
        step();
        csr(2'b00, 12'hB02, 0);           chk("instret_stall", last_rdata, 32'h5);
        instr_retired = 1; step(); instr_retired = 0;
        csr(2'b00, 12'hB02, 0);           chk("instret_inc", last_rdata, 32'h6);

        for (int i = 0; i < 3000; i++) begin
            reset_n       = (i != 1500);
            csr_en        = ($urandom_range(0, 3) != 0);
            csr_op        = 2'($urandom);
            csr_addr      = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                                                        : addr_tab[$urandom_range(0, 13)];
            csr_wdata     = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
            mcause_update = ($urandom_range(0, 19) == 0);
            mcause        = 32'($urandom);
            mepc_updata   = 1'($urandom);
            pc_wb         = 32'($urandom);
            is_mret       = ($urandom_range(0, 14) == 0);
            instr_retired = 1'($urandom);
            if ($urandom_range(0, 7) == 0) irq_extern = ~irq_extern;
            if ($urandom_range(0, 7) == 0) irq_soft   = ~irq_soft;
            if ($urandom_range(0, 7) == 0) irq_timer  = ~irq_timer;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
